montgomery_reduce_pipe: RTL and testbench
=========================================

# montgomery_reduce_pipe

Fully pipelined, parametrised Montgomery reduction unit for the Dilithium arithmetic datapath: computes r ≡ a·2^-DATA_W mod Q for LANES independent lanes per beat. It accepts one beat per cycle under a valid/ready handshake with backpressure, and carries a sideband tag through unchanged. It is the streaming replacement for the single-shot start/done reducer. It sits behind the NTT butterfly and pointwise multipliers.

## Interface
- DATA_W, 32, coefficient width; input products are 2·DATA_W signed
- Q, 8380417, modulus (odd, < 2^(DATA_W-1))
- QINV, 58728449, Q^-1 mod 2^DATA_W
- LANES, 1, parallel lanes per beat (1..8)
- TAG_W, 4, sideband tag width (≥1)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  LANES·2·DATA_W  signed products; lane i at bits [i·2·DATA_W +: 2·DATA_W]
- in_tag  in  TAG_W  sideband, returned with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_r  out  LANES·DATA_W  signed results; lane i at [i·DATA_W +: DATA_W]
- out_tag  out  TAG_W  tag of the beat

## Operation
- Per lane: t = signed low DATA_W bits of (a · QINV); r = (a − t·Q) >>> DATA_W (arithmetic). Low DATA_W bits of a − t·Q are zero by construction.
- Valid input range: |a| < 2^(DATA_W-1)·Q. Result range: −Q < r < Q. Out-of-range input gives an undefined value and sets no flag.
- Pipeline stages:
  - S1 registers a and t.
  - S2 registers p = t·Q (2·DATA_W bits) and a.
  - S3 registers r.
- Each stage holds a valid bit, and the tag travels with its beat.
- Global stall: advance = ~out_valid | out_ready. When advance = 0, all stages hold.
- in_ready = advance, combinational from out_valid/out_ready only. There is no path from in_valid to in_ready.
- Bubbles are not compressed: an empty stage still advances only with advance.
- Beats leave in acceptance order. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Reset (reset_n low, async assert): all stage valid bits = 0, out_valid = 0, out_r = 0, out_tag = 0.
- Reset release is synchronous-safe; the first acceptance is possible on the first clock edge after release.
- Reset mid-operation discards all in-flight beats with no output.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+3 if no stall occurs (k+4 with MONTRED_FREEZE_EN).
- Throughput: 1 beat/cycle with out_ready held high.
- When out_ready is low and out_valid is high, out_r and out_tag hold stable until the handshake completes.
- Accept and emit can occur on the same edge when out_ready = 1.

## Configuration
- MONTRED_FREEZE_EN defined:
  - Adds stage S4: r' = r + Q if r < 0, else r.
  - Output is canonical in [0, Q).
  - Latency becomes 4.
- MONTRED_FREEZE_EN undefined:
  - S4 is absent.
  - Output is centered in (−Q, Q).
  - Latency is 3.

## Structure
- Shared package dilithium_pkg holds:
  - DILITHIUM_Q = 8380417
  - DILITHIUM_QINV = 58728449
  - DILITHIUM_DATA_W = 32
  - These are the default values for this block's parameters.
- One sub-module, montgomery_lane, contains the per-lane S1–S3(/S4) datapath with an enable input. It is instantiated LANES times by a generate loop.
- The top level owns the valid bits, the tag pipeline and the handshake.

## Test plan
- Defaults, LANES=1, out_ready=1:
  - a=0 → r=0
  - a=2^32 → r=1
  - a=8380417 → r=0
  - a=1 → r=−114592 (8265825 with freeze)
  - a=−2^32 → r=−1 (8380416 with freeze)
  - Each result appears exactly 3 (4) cycles after acceptance.
- Streaming: 64 back-to-back random beats within the valid input range, out_ready=1 → one result per cycle, in order, matching the reference model, with tags 0..15 wrapping.
- Backpressure: random out_ready at 30% duty → no loss, duplication or reorder; out_r and out_tag stable while stalled; in_ready=0 whenever out_valid & ~out_ready.
- LANES=4: lanes driven with a = {1, 2^32, −2^32, Q} → lane results {−114592, 1, −1, 0}, with no cross-lane mixing.
- Async reset: assert reset_n low mid-stream with 3 beats in flight → out_valid falls immediately without waiting for an edge, and no stale beat is emitted after release; the next accepted beat returns a correct result.
- Boundary: a = ±(2^31·Q − 1) → result in (−Q, Q) and congruent to a·2^-32 mod Q.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared Dilithium arithmetic constants.
//   DILITHIUM_Q / DILITHIUM_QINV / DILITHIUM_DATA_W : modulus, Q^-1 mod 2^32, word width
//   MONTRED_STAGES : pipeline depth of montgomery_reduce_pipe. It is 4 when the
//                    MONTRED_FREEZE_EN macro is defined and 3 otherwise.
package dilithium_pkg;

    localparam int unsigned DILITHIUM_Q      = 8380417;
    localparam int unsigned DILITHIUM_QINV   = 58728449;
    localparam int unsigned DILITHIUM_DATA_W = 32;

`ifdef MONTRED_FREEZE_EN
    localparam int unsigned MONTRED_STAGES = 4;
`else
    localparam int unsigned MONTRED_STAGES = 3;
`endif

endpackage

// File: rtl/montgomery_lane.sv
// One lane of the Montgomery reduction datapath: r = (a - t*Q) >>> DATA_W,
// where t = signed low DATA_W bits of a*QINV.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   en             : advance all stages (global pipeline advance)
//   a              : 2*DATA_W signed product
//   r              : DATA_W signed result. It is centered in (-Q, Q), or
//                    canonical in [0, Q) when MONTRED_FREEZE_EN is defined,
//                    which adds stage S4.
module montgomery_lane
    import dilithium_pkg::*;
#(
    parameter int unsigned DATA_W = DILITHIUM_DATA_W,
    parameter int unsigned Q      = DILITHIUM_Q,
    parameter int unsigned QINV   = DILITHIUM_QINV
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [2*DATA_W-1:0]   a,
    output logic [DATA_W-1:0]     r
);

    localparam int unsigned       W2     = 2 * DATA_W;
    localparam logic [DATA_W-1:0] QINV_W = DATA_W'(QINV);
    localparam logic [DATA_W-1:0] Q_W    = DATA_W'(Q);
    localparam logic [W2-1:0]     Q_X    = W2'(Q);

    logic [W2-1:0]     a1_q, a1_d, a2_q, a2_d, p2_q, p2_d;
    logic [DATA_W-1:0] t1_q, t1_d, r3_q, r3_d;
`ifdef MONTRED_FREEZE_EN
    logic [DATA_W-1:0] r4_q, r4_d;
`endif

    always_comb begin
        a1_d = a1_q;
        t1_d = t1_q;
        a2_d = a2_q;
        p2_d = p2_q;
        r3_d = r3_q;
`ifdef MONTRED_FREEZE_EN
        r4_d = r4_q;
`endif
        if (en) begin
            // S1: only the low DATA_W bits of a*QINV matter, so an unsigned
            // DATA_W-bit product gives the same bits as the signed one.
            a1_d = a;
            t1_d = a[DATA_W-1:0] * QINV_W;
            // S2: sign-extend t so the 2*DATA_W product is the signed t*Q.
            a2_d = a1_q;
            p2_d = {{DATA_W{t1_q[DATA_W-1]}}, t1_q} * Q_X;
            // S3: the low half of a - t*Q is zero, so its top half is the
            // arithmetic shift truncated to DATA_W bits.
            r3_d = DATA_W'((a2_q - p2_q) >> DATA_W);
`ifdef MONTRED_FREEZE_EN
            r4_d = r3_q[DATA_W-1] ? (r3_q + Q_W) : r3_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a1_q <= '0;
            t1_q <= '0;
            a2_q <= '0;
            p2_q <= '0;
            r3_q <= '0;
`ifdef MONTRED_FREEZE_EN
            r4_q <= '0;
`endif
        end else begin
            a1_q <= a1_d;
            t1_q <= t1_d;
            a2_q <= a2_d;
            p2_q <= p2_d;
            r3_q <= r3_d;
`ifdef MONTRED_FREEZE_EN
            r4_q <= r4_d;
`endif
        end
    end

`ifdef MONTRED_FREEZE_EN
    assign r = r4_q;
`else
    assign r = r3_q;
`endif

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Streaming Montgomery reduction, r = a * 2^-DATA_W mod Q, for LANES lanes per beat.
// The unit uses a valid/ready handshake with a global stall and carries a tag
// through with each beat.
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake. in_ready depends only on out_valid and out_ready.
//   in_a                 : lane i at [i*2*DATA_W +: 2*DATA_W], signed
//   in_tag               : sideband tag, returned unchanged with the beat
//   out_valid/out_ready  : output handshake
//   out_r                : lane i at [i*DATA_W +: DATA_W], signed
//   out_tag              : tag of the output beat
// When MONTRED_FREEZE_EN is defined, the pipeline gains a stage that makes
// the results canonical in [0, Q). Latency is then 4 instead of 3.
module montgomery_reduce_pipe
    import dilithium_pkg::*;
#(
    parameter int unsigned DATA_W = DILITHIUM_DATA_W,
    parameter int unsigned Q      = DILITHIUM_Q,
    parameter int unsigned QINV   = DILITHIUM_QINV,
    parameter int unsigned LANES  = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*2*DATA_W-1:0]   in_a,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_W-1:0]     out_r,
    output logic [TAG_W-1:0]            out_tag
);

    localparam int unsigned NS = MONTRED_STAGES;

    logic [NS-1:0]            vld_q, vld_d;
    logic [NS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic                     advance;

    // Every stage moves together. Bubbles travel like beats, so the lane
    // datapaths need only the shared enable.
    always_comb begin
        advance = ~vld_q[NS-1] | out_ready;
        vld_d   = vld_q;
        tag_d   = tag_q;
        if (advance) begin
            vld_d = {vld_q[NS-2:0], in_valid};
            tag_d = {tag_q[NS-2:0], in_tag};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[NS-1];
    assign out_tag   = tag_q[NS-1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        montgomery_lane #(
            .DATA_W (DATA_W),
            .Q      (Q),
            .QINV   (QINV)
        ) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (advance),
            .a       (in_a[i*2*DATA_W +: 2*DATA_W]),
            .r       (out_r[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
module tb_montgomery_reduce_pipe;

    localparam longint Q    = 8380417;
    localparam longint QINV = 58728449;
    localparam int     NL   = 4;
`ifdef MONTRED_FREEZE_EN
    localparam int     LAT  = 4;
`else
    localparam int     LAT  = 3;
`endif

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [255:0]   in_a = '0;
    logic [3:0]     in_tag = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   out_r;
    logic [3:0]     out_tag;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [127:0] r; logic [3:0] tag; } beat_t;
    beat_t exp_q[$];

    montgomery_reduce_pipe #(.LANES(NL), .TAG_W(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    // Montgomery result from the defining formula, in plain 64-bit arithmetic.
    function automatic longint ref_r(input longint a);
        longint t, r;
        t = longint'(int'(a * QINV));
        r = (a - t * Q) >>> 32;
`ifdef MONTRED_FREEZE_EN
        if (r < 0) r += Q;
`endif
        return r;
    endfunction

    function automatic longint fz(input longint e);
`ifdef MONTRED_FREEZE_EN
        if (e < 0) return e + Q;
`endif
        return e;
    endfunction

    function automatic longint rand_a();
        longint unsigned lim, mag;
        lim = (64'd1 << 31) * 64'(Q);
        mag = {$urandom, $urandom} % lim;
        return ($urandom_range(0, 1) == 1) ? -longint'(mag) : longint'(mag);
    endfunction

    function automatic logic [255:0] pack4(input longint a0, a1, a2, a3);
        return {64'(a3), 64'(a2), 64'(a1), 64'(a0)};
    endfunction

    function automatic logic [127:0] model_beat(input logic [255:0] a);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < NL; i++) m[i*32 +: 32] = 32'(ref_r($signed(a[i*64 +: 64])));
        return m;
    endfunction

    function automatic longint lane(input logic [127:0] r, input int i);
        return longint'($signed(r[i*32 +: 32]));
    endfunction

    // Sends one beat into an empty pipe and waits a bounded time for its result.
    task automatic send_one(input logic [255:0] a, input logic [3:0] tag,
                            output int cycles, output logic v,
                            output logic [127:0] r, output logic [3:0] t);
        @(negedge clock);
        in_a = a; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        cycles = 1;
        while (!out_valid && cycles < 12) begin
            @(negedge clock);
            cycles++;
        end
        v = out_valid; r = out_r; t = out_tag;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_r !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_state valid=%b r=%h tag=%h want 0/0/0", out_valid, out_r, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_directed;
        longint da[5] = '{0, 64'sd1 <<< 32, Q, 1, -(64'sd1 <<< 32)};
        longint de[5] = '{0, 1, 0, -114592, -1};
        longint o1, o2, o3;
        int cyc; logic v; logic [127:0] r; logic [3:0] t;
        for (int i = 0; i < 5; i++) begin
            o1 = rand_a(); o2 = rand_a(); o3 = rand_a();
            send_one(pack4(da[i], o1, o2, o3), 4'(i), cyc, v, r, t);
            checks++;
            if (v !== 1'b1 || cyc != LAT) begin
                errors++;
                $display("FAIL directed_latency[%0d] got valid=%b cycles=%0d want 1/%0d", i, v, cyc, LAT);
            end
            checks++;
            if (lane(r, 0) != fz(de[i]) || t !== 4'(i)) begin
                errors++;
                $display("FAIL directed_value[%0d] got r=%0d tag=%0d want r=%0d tag=%0d",
                         i, lane(r, 0), t, fz(de[i]), i);
            end
            checks++;
            if (lane(r, 1) != ref_r(o1) || lane(r, 2) != ref_r(o2) || lane(r, 3) != ref_r(o3)) begin
                errors++;
                $display("FAIL directed_other_lanes[%0d] got %h want %0d %0d %0d",
                         i, r, ref_r(o1), ref_r(o2), ref_r(o3));
            end
        end
    endtask

    task automatic test_lanes;
        longint e[4] = '{-114592, 1, -1, 0};
        int cyc; logic v; logic [127:0] r; logic [3:0] t;
        send_one(pack4(1, 64'sd1 <<< 32, -(64'sd1 <<< 32), Q), 4'hA, cyc, v, r, t);
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (v !== 1'b1 || lane(r, i) != fz(e[i])) begin
                errors++;
                $display("FAIL lanes[%0d] got valid=%b r=%0d want 1/%0d", i, v, lane(r, i), fz(e[i]));
            end
        end
    endtask

    task automatic test_boundary;
        longint b, a[4], r;
        int cyc; logic v; logic [127:0] ro; logic [3:0] t;
        b = (64'sd1 <<< 31) * Q - 1;
        a[0] = b; a[1] = -b; a[2] = b - 1; a[3] = -b + 1;
        send_one(pack4(a[0], a[1], a[2], a[3]), 4'h5, cyc, v, ro, t);
        for (int i = 0; i < NL; i++) begin
            r = lane(ro, i);
            checks++;
`ifdef MONTRED_FREEZE_EN
            if (v !== 1'b1 || r < 0 || r >= Q || ((r <<< 32) - a[i]) % Q != 0 || r != ref_r(a[i])) begin
`else
            if (v !== 1'b1 || r <= -Q || r >= Q || ((r <<< 32) - a[i]) % Q != 0 || r != ref_r(a[i])) begin
`endif
                errors++;
                $display("FAIL boundary[%0d] a=%0d got r=%0d want %0d (in range, congruent)",
                         i, a[i], r, ref_r(a[i]));
            end
        end
    endtask

    task automatic test_stream;
        int sent = 0, recv = 0, cyc = 0, first = -1, last = -1;
        beat_t b;
        out_ready = 1'b1;
        while ((sent < 64 || recv < 64) && cyc < 300) begin
            @(negedge clock);
            in_valid = (sent < 64);
            in_a = pack4(rand_a(), rand_a(), rand_a(), rand_a());
            in_tag = 4'(sent);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got tag=%0d want no beat", out_tag);
                end else begin
                    b = exp_q.pop_front();
                    if (out_r !== b.r || out_tag !== b.tag) begin
                        errors++;
                        $display("FAIL stream_beat[%0d] got r=%h tag=%0d want r=%h tag=%0d",
                                 recv, out_r, out_tag, b.r, b.tag);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{r: model_beat(in_a), tag: in_tag});
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 64 || last - first != 63) begin
            errors++;
            $display("FAIL stream_throughput got recv=%0d span=%0d want 64/63", recv, last - first);
        end
    endtask

    task automatic test_backpressure;
        int sent = 0, recv = 0, cyc = 0, bad_rdy = 0, bad_hold = 0;
        logic stall = 1'b0;
        logic [127:0] hr;
        logic [3:0] ht;
        beat_t b;
        while ((sent < 100 || recv < 100) && cyc < 3000) begin
            @(negedge clock);
            out_ready = ($urandom_range(0, 9) < 3);
            in_valid = (sent < 100) && ($urandom_range(0, 9) < 7);
            in_a = pack4(rand_a(), rand_a(), rand_a(), rand_a());
            in_tag = 4'($urandom);
            #1;
            if (in_ready !== !(out_valid && !out_ready)) bad_rdy++;
            if (stall && (out_valid !== 1'b1 || out_r !== hr || out_tag !== ht)) bad_hold++;
            stall = out_valid && !out_ready;
            hr = out_r; ht = out_tag;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra got tag=%0d want no beat", out_tag);
                end else begin
                    b = exp_q.pop_front();
                    if (out_r !== b.r || out_tag !== b.tag) begin
                        errors++;
                        $display("FAIL bp_beat[%0d] got r=%h tag=%0d want r=%h tag=%0d",
                                 recv, out_r, out_tag, b.r, b.tag);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{r: model_beat(in_a), tag: in_tag});
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got recv=%0d pending=%0d want 100/0", recv, exp_q.size());
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL bp_in_ready got %0d bad cycles want 0", bad_rdy);
        end
        checks++;
        if (bad_hold != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad_hold);
        end
    endtask

    task automatic test_async_reset;
        int stale = 0, cyc; logic v; logic [127:0] r; logic [3:0] t;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            out_ready = 1'b0; in_valid = 1'b1;
            in_a = pack4(rand_a(), rand_a(), rand_a(), rand_a()); in_tag = 4'(i + 1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_precond got valid=%b want 1", out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_r !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL rst_async got valid=%b r=%h tag=%h want 0/0/0", out_valid, out_r, out_tag);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_stale got %0d beats want 0", stale);
        end
        send_one(pack4(64'sd1 <<< 32, Q, 1, 0), 4'h7, cyc, v, r, t);
        checks++;
        if (v !== 1'b1 || cyc != LAT || lane(r, 0) != 1 || lane(r, 1) != 0 ||
            lane(r, 2) != fz(-114592) || t !== 4'h7) begin
            errors++;
            $display("FAIL rst_recover got valid=%b cyc=%0d r=%h tag=%0d want 1/%0d lanes 1,0,%0d tag 7",
                     v, cyc, r, t, LAT, fz(-114592));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_lanes();
        test_boundary();
        test_stream();
        test_backpressure();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
